tank_move_scheduler: RTL and testbench
======================================

Name: tank_move_scheduler

Overview:
- Per-frame sequencer that shares the move-issue slot between the two tank instances.
- On each frame tick, checks each tank's requested direction against arena bounds and the other tank's footprint, substitutes STAND when blocked, and issues one valid_take_direction pulse per tank in round-robin order.
- Sits between the game controller/input decoder and the two tank blocks.
- Two tanks only.

Parameters:
MAP_W, 40, arena width in cells; legal centre x range is [TANK_HALF, MAP_W-1-TANK_HALF]
MAP_H, 30, arena height in cells; legal centre y range is [TANK_HALF, MAP_H-1-TANK_HALF]
TANK_HALF, 1, tank half-size; footprint is (2*TANK_HALF+1) square around the centre

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
game_state  in  2  00 IDLE, 01 PLAY, 10 RESTART, 11 OVER
frame_tick  in  1  one-cycle pulse at start of each game frame
req_dir0  in  3  tank 0 requested direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 STAND
req_dir1  in  3  tank 1 requested direction, same encoding
tank0_x, tank0_y  in  6 each  tank 0 current centre
tank1_x, tank1_y  in  6 each  tank 1 current centre
dir_out0  out  3  direction issued to tank 0
dir_out1  out  3  direction issued to tank 1
valid_take0  out  1  one-cycle issue strobe to tank 0
valid_take1  out  1  one-cycle issue strobe to tank 1
busy  out  1  high while a frame sequence is in progress
frame_done  out  1  one-cycle pulse when both tanks have been issued
overrun  out  1  one-cycle pulse when frame_tick arrives while busy

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - FSM IDLE; first_q=0 (tank 0 first).
  - dir_out0/1=4 (STAND).
  - valid_take0/1=0; busy=0; frame_done=0; overrun=0.
- FSM states: IDLE, CHK_A, ISS_A, CHK_B, ISS_B. A = tank first_q, B = the other tank.
- IDLE -> CHK_A when frame_tick=1 and game_state=01; otherwise stay in IDLE.
- CHK_A (cycle T+1, tick at T):
  - Sample A's request and both positions.
  - Register legal_dir (request, or 4 if blocked).
- ISS_A (T+2): valid_take_A=1; dir_out_A=legal_dir.
- CHK_B (T+3): evaluate B against positions as seen in T+3, which includes any A move committed at end of T+2.
- ISS_B (T+4): valid_take_B=1; dir_out_B=legal_dir.
- Return to IDLE at T+5. In T+5: frame_done=1 and first_q toggles.
- busy=1 exactly in cycles T+1..T+4.
- All outputs registered. dir_outX holds its value between strobes. At most one valid_take high per cycle.
- Legality (combinational, per candidate):
  - Request >4 is treated as 4. STAND is always legal.
  - Next centre = current ±1 on one axis; arithmetic is 7-bit signed.
  - Blocked if next centre lies outside the legal range.
  - Blocked if |nx-ox| <= 2*TANK_HALF and |ny-oy| <= 2*TANK_HALF, where (ox,oy) is the other tank's centre.
- game_state leaves 01 while busy:
  - FSM returns to IDLE next cycle; no further strobes; no frame_done; first_q unchanged.
  - dir_outs keep their last values.
- game_state=10 (RESTART): additionally forces dir_out0/1=4 and first_q=0 next cycle.
- frame_tick while busy: ignored; overrun=1 for one cycle.
- frame_tick in the same cycle the FSM returns to IDLE (T+5): accepted, CHK_A starts T+6.
- Reset mid-sequence: all state to reset values immediately (asynchronous).

Decomposition:
- Shared package tank_pkg holds:
  - direction constants UP/DOWN/LEFT/RIGHT/STAND (3-bit);
  - game_state constants GS_IDLE/GS_PLAY/GS_RESTART/GS_OVER;
  - sched_state_t enum.
- Sub-module tank_move_checker (purely combinational): inputs req_dir, own pos, other pos; parameters MAP_W/MAP_H/TANK_HALF; output legal_dir. Instantiated once and muxed between A and B by state.

Test Plan:
- Reset, PLAY; tank0 (10,10) req RIGHT, tank1 (30,20) req UP; tick at T:
  - valid_take0 at T+2 with dir_out0=3;
  - valid_take1 at T+4 with dir_out1=0;
  - frame_done at T+5.
  - Next tick: tank1 strobed first.
- Boundary: tank0 at (1,5) req LEFT -> dir_out0=4. Tank0 at (38,5) req RIGHT (MAP_W=40) -> dir_out0=4. Tank0 at (37,5) req RIGHT -> 3.
- Collision: tank0 (10,10) req RIGHT, tank1 (13,10) -> dir_out0=4. Tank1 at (14,10) -> dir_out0=3.
- Ordered check: tank0 first at (10,10) req RIGHT, moves to (11,10) at end of T+2; tank1 at (14,10) req LEFT -> dir_out1=4.
- Overrun/abort:
  - Tick at T+2 -> overrun=1 at T+3; no restart of sequence.
  - game_state->10 at T+3 -> no valid_take1, no frame_done, dir_outs=4, first_q=0.
- Request 3'd6 -> issued as 4. rst_n low at T+2 -> valid_take0 drops immediately, all outputs at reset values.

Source files
------------

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared direction, game-state and scheduler-state definitions
package tank_pkg;

    // Tank direction encoding; anything above STAND is treated as STAND.
    localparam logic [2:0] UP    = 3'd0;
    localparam logic [2:0] DOWN  = 3'd1;
    localparam logic [2:0] LEFT  = 3'd2;
    localparam logic [2:0] RIGHT = 3'd3;
    localparam logic [2:0] STAND = 3'd4;

    // Game controller state encoding.
    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_PLAY    = 2'b01;
    localparam logic [1:0] GS_RESTART = 2'b10;
    localparam logic [1:0] GS_OVER    = 2'b11;

    // A = tank selected by first_q, B = the other tank.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_A,
        S_ISS_A,
        S_CHK_B,
        S_ISS_B
    } sched_state_t;

endpackage

// File: rtl/tank_move_checker.sv
// rtl/tank_move_checker.sv - combinational legality check of one tank's requested move
//
// Ports:
//   req_dir_i            requested direction (values above STAND mean STAND)
//   own_x_i, own_y_i     centre of the tank being checked
//   other_x_i, other_y_i centre of the other tank
//   legal_dir_o          req_dir_i if the move is legal, otherwise STAND
module tank_move_checker
    import tank_pkg::*;
#(
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 30,
    parameter int TANK_HALF = 1
) (
    input  logic [2:0] req_dir_i,
    input  logic [5:0] own_x_i,
    input  logic [5:0] own_y_i,
    input  logic [5:0] other_x_i,
    input  logic [5:0] other_y_i,
    output logic [2:0] legal_dir_o
);

    localparam logic signed [6:0] X_LO = 7'(TANK_HALF);
    localparam logic signed [6:0] X_HI = 7'(MAP_W - 1 - TANK_HALF);
    localparam logic signed [6:0] Y_LO = 7'(TANK_HALF);
    localparam logic signed [6:0] Y_HI = 7'(MAP_H - 1 - TANK_HALF);
    // Two footprints overlap when centres are within 2*TANK_HALF on both axes.
    localparam logic signed [7:0] SPAN = 8'(2 * TANK_HALF);

    logic [2:0]        dir;
    logic signed [6:0] nx;
    logic signed [6:0] ny;
    logic signed [7:0] dx;
    logic signed [7:0] dy;
    logic signed [7:0] adx;
    logic signed [7:0] ady;
    logic              blocked;

    always_comb begin
        dir = (req_dir_i > STAND) ? STAND : req_dir_i;
        nx  = signed'({1'b0, own_x_i});
        ny  = signed'({1'b0, own_y_i});
        case (dir)
            UP:      ny = ny - 7'sd1;
            DOWN:    ny = ny + 7'sd1;
            LEFT:    nx = nx - 7'sd1;
            RIGHT:   nx = nx + 7'sd1;
            default: ;
        endcase
        // Differences are widened to 8 bits so the sign survives |63 - 0|.
        dx  = signed'({nx[6], nx}) - signed'({2'b00, other_x_i});
        dy  = signed'({ny[6], ny}) - signed'({2'b00, other_y_i});
        adx = dx[7] ? -dx : dx;
        ady = dy[7] ? -dy : dy;
        blocked = (nx < X_LO) || (nx > X_HI) || (ny < Y_LO) || (ny > Y_HI)
                  || ((adx <= SPAN) && (ady <= SPAN));
        legal_dir_o = ((dir == STAND) || blocked) ? STAND : dir;
    end

endmodule

// File: rtl/tank_move_scheduler.sv
// rtl/tank_move_scheduler.sv - per-frame round-robin move issue for two tanks
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   game_state                 00 IDLE, 01 PLAY, 10 RESTART, 11 OVER
//   frame_tick                 one-cycle frame start pulse
//   req_dir0/1                 requested directions
//   tank0_x/y, tank1_x/y       current tank centres
//   dir_out0/1                 issued directions (held between strobes)
//   valid_take0/1              one-cycle issue strobes
//   busy                       high while a frame sequence is running
//   frame_done                 pulse after both tanks were issued
//   overrun                    pulse when frame_tick arrives while busy
module tank_move_scheduler
    import tank_pkg::*;
#(
    parameter int MAP_W     = 40,
    parameter int MAP_H     = 30,
    parameter int TANK_HALF = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] game_state,
    input  logic       frame_tick,
    input  logic [2:0] req_dir0,
    input  logic [2:0] req_dir1,
    input  logic [5:0] tank0_x,
    input  logic [5:0] tank0_y,
    input  logic [5:0] tank1_x,
    input  logic [5:0] tank1_y,
    output logic [2:0] dir_out0,
    output logic [2:0] dir_out1,
    output logic       valid_take0,
    output logic       valid_take1,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    sched_state_t state_q;
    logic         first_q;
    logic [2:0]   dir0_q;
    logic [2:0]   dir1_q;
    logic         take0_q;
    logic         take1_q;
    logic         busy_q;
    logic         done_q;
    logic         overrun_q;

    // One checker shared by both phases: CHK_A looks at tank first_q,
    // every other state at the other tank (only CHK_B uses the result).
    logic       sel_t1;
    logic [2:0] legal_dir;

    assign sel_t1 = (state_q == S_CHK_A) ? first_q : ~first_q;

    tank_move_checker #(
        .MAP_W     (MAP_W),
        .MAP_H     (MAP_H),
        .TANK_HALF (TANK_HALF)
    ) u_checker (
        .req_dir_i   (sel_t1 ? req_dir1 : req_dir0),
        .own_x_i     (sel_t1 ? tank1_x  : tank0_x),
        .own_y_i     (sel_t1 ? tank1_y  : tank0_y),
        .other_x_i   (sel_t1 ? tank0_x  : tank1_x),
        .other_y_i   (sel_t1 ? tank0_y  : tank1_y),
        .legal_dir_o (legal_dir)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            first_q   <= 1'b0;
            dir0_q    <= STAND;
            dir1_q    <= STAND;
            take0_q   <= 1'b0;
            take1_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            take0_q   <= 1'b0;
            take1_q   <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= frame_tick && (state_q != S_IDLE);

            if ((state_q != S_IDLE) && (game_state != GS_PLAY)) begin
                // Leaving PLAY mid-frame abandons the rest of the sequence.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (frame_tick && (game_state == GS_PLAY)) begin
                            state_q <= S_CHK_A;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_CHK_A: begin
                        if (first_q) begin
                            take1_q <= 1'b1;
                            dir1_q  <= legal_dir;
                        end else begin
                            take0_q <= 1'b1;
                            dir0_q  <= legal_dir;
                        end
                        state_q <= S_ISS_A;
                    end
                    S_ISS_A: begin
                        state_q <= S_CHK_B;
                    end
                    S_CHK_B: begin
                        if (first_q) begin
                            take0_q <= 1'b1;
                            dir0_q  <= legal_dir;
                        end else begin
                            take1_q <= 1'b1;
                            dir1_q  <= legal_dir;
                        end
                        state_q <= S_ISS_B;
                    end
                    S_ISS_B: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        first_q <= ~first_q;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end

            if (game_state == GS_RESTART) begin
                dir0_q  <= STAND;
                dir1_q  <= STAND;
                first_q <= 1'b0;
            end
        end
    end

    assign dir_out0    = dir0_q;
    assign dir_out1    = dir1_q;
    assign valid_take0 = take0_q;
    assign valid_take1 = take1_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_tank_move_scheduler.sv
// tb/tb_tank_move_scheduler.sv - self-checking bench for tank_move_scheduler
module tb_tank_move_scheduler;
    import tank_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] game_state = GS_IDLE;
    logic       frame_tick = 1'b0;
    logic [2:0] req_dir0 = STAND;
    logic [2:0] req_dir1 = STAND;
    logic [5:0] tank0_x = 6'd10;
    logic [5:0] tank0_y = 6'd10;
    logic [5:0] tank1_x = 6'd30;
    logic [5:0] tank1_y = 6'd20;
    logic [2:0] dir_out0;
    logic [2:0] dir_out1;
    logic       valid_take0;
    logic       valid_take1;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    tank_move_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_state  (game_state),
        .frame_tick  (frame_tick),
        .req_dir0    (req_dir0),
        .req_dir1    (req_dir1),
        .tank0_x     (tank0_x),
        .tank0_y     (tank0_y),
        .tank1_x     (tank1_x),
        .tank1_y     (tank1_y),
        .dir_out0    (dir_out0),
        .dir_out1    (dir_out1),
        .valid_take0 (valid_take0),
        .valid_take1 (valid_take1),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int nvec = 0;
    int nfail = 0;
    bit first = 1'b0;

    typedef struct {
        int tank;
        int dir;
        int cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int x0, y0, x1, y1, r0, r1, e0, e1;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer; also moves the tanks the way the tank blocks would.
    initial forever begin
        @(negedge clk);
        if (valid_take0 || valid_take1) begin
            int t;
            int d;
            exp_t e;
            chk("single_strobe", int'(valid_take0 && valid_take1), 0);
            t = valid_take1 ? 1 : 0;
            d = t ? int'(dir_out1) : int'(dir_out0);
            if (sb.size() == 0) begin
                chk("unexpected_strobe_tank", t, -1);
            end else begin
                e = sb.pop_front();
                chk("strobe_tank", t, e.tank);
                chk("strobe_dir", d, e.dir);
                chk("strobe_cycle", cyc, e.cyc);
            end
            if (t == 0) begin
                case (d)
                    0: tank0_y = tank0_y - 6'd1;
                    1: tank0_y = tank0_y + 6'd1;
                    2: tank0_x = tank0_x - 6'd1;
                    3: tank0_x = tank0_x + 6'd1;
                    default: ;
                endcase
            end else begin
                case (d)
                    0: tank1_y = tank1_y - 6'd1;
                    1: tank1_y = tank1_y + 6'd1;
                    2: tank1_x = tank1_x - 6'd1;
                    3: tank1_x = tank1_x + 6'd1;
                    default: ;
                endcase
            end
        end
    end

    task automatic load(input vec_t v);
        tank0_x  = 6'(v.x0);
        tank0_y  = 6'(v.y0);
        tank1_x  = 6'(v.x1);
        tank1_y  = 6'(v.y1);
        req_dir0 = 3'(v.r0);
        req_dir1 = 3'(v.r1);
    endtask

    task automatic push_frame(input int e0, input int e1, input int t);
        exp_t a;
        exp_t b;
        a.tank = first ? 1 : 0;
        a.dir  = first ? e1 : e0;
        a.cyc  = t + 2;
        b.tank = first ? 0 : 1;
        b.dir  = first ? e0 : e1;
        b.cyc  = t + 4;
        sb.push_back(a);
        sb.push_back(b);
    endtask

    // Called at a negedge; the tick is driven in cycle T = cyc.
    task automatic run_frame(input vec_t v);
        int t;
        load(v);
        t = cyc;
        push_frame(v.e0, v.e1, t);
        frame_tick = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            chk("busy", int'(busy), int'(k <= 4));
            chk("frame_done", int'(frame_done), int'(k == 5));
            chk("overrun", int'(overrun), 0);
        end
        chk("sb_empty", sb.size(), 0);
        first = ~first;
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int t;

        //           x0  y0  x1  y1  r0 r1  e0 e1
        tbl[0] = '{10, 10, 30, 20, 3, 0, 3, 0};  // basic, tank0 first
        tbl[1] = '{ 1,  5, 30, 20, 2, 4, 4, 4};  // left wall, tank1 first
        tbl[2] = '{38,  5, 20, 20, 3, 1, 4, 1};  // right wall
        tbl[3] = '{37,  5, 30, 20, 3, 2, 3, 2};  // right edge still legal
        tbl[4] = '{10, 10, 13, 10, 3, 4, 4, 4};  // footprint collision
        tbl[5] = '{10, 10, 14, 10, 3, 4, 3, 4};  // just clear of other tank
        tbl[6] = '{10, 10, 14, 10, 3, 2, 3, 4};  // B sees A's committed move
        tbl[7] = '{ 5,  5, 20, 20, 0, 6, 0, 4};  // out-of-range request
        tbl[8] = '{ 5,  1, 20, 28, 0, 1, 4, 4};  // top and bottom walls
        tbl[9] = '{10, 10, 10, 14, 1, 0, 4, 0};  // vertical, tank1 moves first

        repeat (3) @(negedge clk);
        chk("rst_dir0", int'(dir_out0), 4);
        chk("rst_dir1", int'(dir_out1), 4);
        chk("rst_take", int'({valid_take0, valid_take1}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done_ovr", int'({frame_done, overrun}), 0);
        rst_n = 1'b1;
        game_state = GS_PLAY;
        @(negedge clk);

        foreach (tbl[i]) run_frame(tbl[i]);

        // Overrun: second tick in T+2 is flagged in T+3 and otherwise ignored.
        v = '{10, 10, 30, 20, 4, 4, 4, 4};
        load(v);
        t = cyc;
        push_frame(4, 4, t);
        frame_tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            chk("ovr_busy", int'(busy), int'(k <= 4));
            chk("ovr_done", int'(frame_done), int'(k == 5));
            chk("ovr_flag", int'(overrun), int'(k == 3));
            if (k == 2) frame_tick = 1'b1;
        end
        chk("ovr_sb_empty", sb.size(), 0);
        first = ~first;

        // RESTART at T+3 with tank1 first: no second strobe, dirs forced to STAND.
        v = '{10, 10, 30, 20, 3, 0, 0, 0};
        load(v);
        t = cyc;
        e = '{1, 0, t + 2};
        sb.push_back(e);
        frame_tick = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            chk("rs_busy", int'(busy), int'(k <= 3));
            chk("rs_done", int'(frame_done), 0);
            if (k == 4) begin
                chk("rs_dir0", int'(dir_out0), 4);
                chk("rs_dir1", int'(dir_out1), 4);
            end
            if (k == 3) game_state = GS_RESTART;
        end
        chk("rs_sb_empty", sb.size(), 0);
        game_state = GS_PLAY;
        first = 1'b0;
        run_frame(tbl[0]);
        run_frame(tbl[1]);

        // Asynchronous reset while tank0's strobe is high.
        v = '{10, 10, 30, 20, 3, 0, 3, 0};
        load(v);
        t = cyc;
        e = '{0, 3, t + 2};
        sb.push_back(e);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_take0", int'(valid_take0), 0);
        chk("ar_take1", int'(valid_take1), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_dir0", int'(dir_out0), 4);
        chk("ar_dir1", int'(dir_out1), 4);
        chk("ar_done_ovr", int'({frame_done, overrun}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ar_idle_busy", int'(busy), 0);
        end
        chk("ar_sb_empty", sb.size(), 0);
        first = 1'b0;
        run_frame(tbl[6]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
